// File: rtl/shift_add_multiplier.sv
// Sequential radix-2 shift-and-add multiplier built around one claBlock adder.
// Define MULT_SIGNED_EN for two's-complement operands and product.

module claBlock #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic          cIn,
    output logic [W-1:0] sum
);

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W-1:0] w_c;

    // Generate/propagate terms and carry chain.
    always_comb begin
        w_g    = a & b;
        w_p    = a ^ b;
        w_c    = '0;
        w_c[0] = cIn;
        for (int i = 0; i < W - 1; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
        sum = w_p ^ w_c;
    end

endmodule

module shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_mcand;
    logic [N-1:0]   r_acc;
    logic [N-1:0]   r_mq;
    logic [CW-1:0]  r_count;
    logic [2*N-1:0] r_product;
    logic [N-1:0]   w_addend;
    logic [N:0]     w_sum;
    logic [2*N-1:0] w_shifted;
    logic [2*N-1:0] w_result;
    logic [N-1:0]   w_a_load;
    logic [N-1:0]   w_b_load;

    assign w_addend  = r_mq[0] ? r_mcand : {N{1'b0}};
    assign w_shifted = {w_sum, r_mq[N-1:1]};

    claBlock #(.W(N + 1)) u_cla (
        .a   ({1'b0, r_acc}),
        .b   ({1'b0, w_addend}),
        .cIn (1'b0),
        .sum (w_sum)
    );

`ifdef MULT_SIGNED_EN
    logic r_neg;
    // Operands enter the datapath as magnitudes; the sign is reapplied at the end.
    assign w_a_load = a[N-1] ? (-a) : a;
    assign w_b_load = b[N-1] ? (-b) : b;
    assign w_result = r_neg ? (-w_shifted) : w_shifted;
`else
    assign w_a_load = a;
    assign w_b_load = b;
    assign w_result = w_shifted;
`endif

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_count == LAST) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_CALC;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand load, shift/accumulate, and result capture on the final add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mq      <= '0;
            r_count   <= '0;
            r_product <= '0;
`ifdef MULT_SIGNED_EN
            r_neg     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= w_a_load;
                        r_mq    <= w_b_load;
                        r_acc   <= '0;
                        r_count <= '0;
`ifdef MULT_SIGNED_EN
                        r_neg   <= a[N-1] ^ b[N-1];
`endif
                    end
                end
                S_CALC: begin
                    {r_acc, r_mq} <= w_shifted;
                    r_count       <= r_count + {{(CW-1){1'b0}}, 1'b1};
                    if (r_count == LAST) begin
                        r_product <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready   = (r_state == S_IDLE);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier with a product scoreboard.
// Expectations follow MULT_SIGNED_EN when it is defined for the build.

module tb_shift_add_multiplier;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*N-1:0] product;

    int n_checks = 0;
    int n_errors = 0;
    bit overlap_seen = 1'b0;
    logic [2*N-1:0] exp_q[$];

    shift_add_multiplier #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    // Handshake outputs must never be asserted together.
    always @(negedge clk) begin
        if (ready === 1'b1 && done === 1'b1) overlap_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2*N-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
`ifdef MULT_SIGNED_EN
        logic signed [2*N-1:0] s;
        s = $signed(x) * $signed(y);
        return s;
`else
        return {{N{1'b0}}, x} * {{N{1'b0}}, y};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watch for stray done pulses; product must hold meanwhile.
    task automatic quiet(input string tag, input int cycles);
        int dones;
        logic [2*N-1:0] held;
        dones = 0;
        held  = product;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk({tag, "_no_done"}, dones, 0);
        chk({tag, "_hold"}, product, held);
    endtask

    // One multiply; poke>0 pulses a rejected start at that cycle of the operation.
    task automatic run_op(input string tag, input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                          input int poke);
        int lat;
        bit got;
        logic [2*N-1:0] exp_p;
        @(negedge clk);
        chk({tag, "_ready_before"}, ready, 1'b1);
        a = op_a;
        b = op_b;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(op_a, op_b));
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        got = 1'b0;
        lat = 1;
        while (!got && lat <= 40) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                start = (lat == poke);
                if (lat == poke) begin
                    a = 8'h10;
                    b = 8'h10;
                end
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, got ? lat : 0, N + 1);
        exp_p = exp_q.pop_front();
        chk({tag, "_product"}, product, exp_p);
        chk({tag, "_ready_in_done"}, ready, 1'b0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_ready_after"}, ready, 1'b1);
        chk({tag, "_product_held"}, product, exp_p);
    endtask

    initial begin
        int d1;
        int d2;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 1'b1);
        chk("reset_done", done, 1'b0);
        chk("reset_product", product, 0);
        rst = 1'b0;

        run_op("basic_0f_0a", 8'h0F, 8'h0A, 0);
        run_op("max_ff_ff", 8'hFF, 8'hFF, 0);
        run_op("zero_00_a5", 8'h00, 8'hA5, 0);
        run_op("ff_02", 8'hFF, 8'h02, 0);
        run_op("80_80", 8'h80, 8'h80, 0);
        run_op("7f_81", 8'h7F, 8'h81, 0);

        run_op("busy_03_05", 8'h03, 8'h05, 3);
        quiet("busy_after", 12);

        // Abandon an operation partway through CALC.
        @(negedge clk);
        a = 8'h33;
        b = 8'h44;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_done", done, 1'b0);
        chk("midrst_product", product, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet("midrst", 15);
        run_op("post_rst_02_03", 8'h02, 8'h03, 0);

        // Start held high: accepted again as soon as ready returns.
        @(negedge clk);
        a = 8'h11;
        b = 8'h11;
        start = 1'b1;
        exp_q.push_back(model(8'h11, 8'h11));
        exp_q.push_back(model(8'h11, 8'h11));
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 11) start = 1'b0;
            if (done === 1'b1) begin
                if (d1 == 0) begin
                    d1 = c;
                    chk("b2b_first_product", product, exp_q.pop_front());
                end else if (d2 == 0) begin
                    d2 = c;
                    chk("b2b_second_product", product, exp_q.pop_front());
                end else begin
                    chk("b2b_extra_done", c, 0);
                end
            end
        end
        chk("b2b_first_latency", d1, N + 1);
        chk("b2b_spacing", d2 - d1, N + 2);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("ready_done_overlap", overlap_seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
